beta_fetch_stage: RTL and testbench
===================================

# beta_fetch_stage

Instruction fetch stage of the Bourbon 3-stage pipeline. Sits between the pipeline control unit and the instruction memory port. It is the responder to the control unit's fetch-enable/busy protocol and the initiator on the imem request/grant/valid handshake. Each accepted fetch enable produces exactly one registered instruction/PC pair for the if-to-dec pipe. A control-hazard redirect reloads the PC and discards any in-flight response.

## Interface
Parameters:
- DataWidth, 32, width of PC and address lines
- BootAddr, 32'h0000_0000, PC value after reset

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous and active-high
- ifs_fetch_en_i  in  1  fetch request pulse from the pipeline control unit
- ifs_busy_o  out  1  high while a fetch is in progress (state != IDLE)
- imem_req_o  out  1  imem request, high in REQ
- imem_addr_o  out  DataWidth  word-aligned fetch address (current PC)
- imem_gnt_i  in  1  imem accepted the request this cycle
- imem_rvalid_i  in  1  imem read data valid this cycle
- imem_rdata_i  in  32  instruction word
- ifs_redirect_i  in  1  control-hazard redirect, one-cycle pulse
- ifs_redirect_addr_i  in  DataWidth  redirect target; bits [1:0] ignored
- ifs_instr_o  out  32  fetched instruction, registered
- ifs_pc_o  out  DataWidth  PC of ifs_instr_o, registered
- ifs_valid_o  out  1  ifs_instr_o holds a valid, non-flushed instruction

## Operation
- FSM states: IDLE, REQ, WAIT.
- Registers: pc, discard flag, output registers.
- Transitions:
  - IDLE: fetch_en=1 -> REQ.
  - REQ: gnt=1 -> WAIT.
  - WAIT: rvalid=1 and discard=0 -> capture, then IDLE.
  - WAIT: rvalid=1 and discard=1 -> clear discard, then REQ (refetch at the new PC; busy stays high).
- Capture:
  - instr_o <= rdata.
  - pc_o <= pc.
  - valid_o <= 1.
  - pc <= pc + 4, modulo 2^DataWidth (0xFFFF_FFFC wraps to 0).
- Outputs hold their value between captures.
- ifs_fetch_en_i is ignored outside IDLE.
- imem_rvalid_i is ignored outside WAIT.
- Redirect (highest priority over the PC increment):
  - pc <= {redirect_addr[DataWidth-1:2], 2'b00}.
  - valid_o <= 0 in the same edge.
  - IDLE: no state change.
  - REQ with gnt=0: stay in REQ; the address switches next cycle.
  - REQ with gnt=1: go to WAIT with discard=1.
  - WAIT with rvalid=0: set discard=1.
  - WAIT with rvalid=1: drop the data, do not capture, go to REQ.
- Redirect and fetch_en in the same cycle while in IDLE: take both; go to REQ with the redirected PC.
- Reset values (asynchronous, immediate):
  - state=IDLE, pc=BootAddr, discard=0.
  - imem_req_o=0, ifs_busy_o=0, ifs_valid_o=0.
  - ifs_instr_o=32'h0000_0013 (NOP), ifs_pc_o=BootAddr.
  - Reset mid-fetch aborts; a late rvalid after reset is ignored because the state is IDLE.

## Timing
- imem_req_o, imem_addr_o and ifs_busy_o decode from registered state and pc; there is no combinational path from imem inputs to them.
- Best-case latency (gnt in the REQ cycle, rvalid the following cycle):
  - fetch_en at cycle 0.
  - req/busy=1 at cycle 1.
  - rvalid at cycle 2.
  - instr_o/valid_o updated and busy_o=0 at cycle 3.
- Each extra gnt or rvalid wait cycle adds one cycle. The busy falling edge coincides with new output data, which the control unit relies on.
- imem_addr_o must stay stable while imem_req_o=1 and gnt=0, except for a redirect.
- Back-to-back fetches: busy drops at cycle N; fetch_en at cycle N gives req at cycle N+1.

## Structure
- beta_pkg additions:
  - ifs_state_t enum {IDLE, REQ, WAIT}.
  - NOP_INSTR constant 32'h0000_0013.
  - INSTR_WIDTH=32.
- Single module, no sub-module. The PC increment and redirect mux are inline.

## Test plan
- Reset then fetch_en pulse; gnt immediate, rvalid next cycle with 0x00500093:
  - instr_o=0x00500093, pc_o=0x0, valid_o=1 at cycle 3.
  - busy high in cycles 1–2.
  - next imem_addr_o=0x4.
- gnt delayed 3 cycles and rvalid delayed 2: address held at 0x4 throughout; capture 5 cycles after the baseline.
- Redirect to 0x103 while in WAIT; stale rvalid data 0xDEADBEEF arrives:
  - data dropped, valid_o=0.
  - new req at address 0x100 with busy held high.
  - the next rvalid is captured with pc_o=0x100.
- Redirect coincident with gnt in REQ: WAIT with discard; first rvalid dropped, refetch at the target.
- Redirect to 0xFFFF_FFFC, then fetch: pc_o=0xFFFF_FFFC; next fetch address is 0x0.
- rst_i asserted in WAIT, released, then rvalid:
  - outputs immediately return to reset values (NOP, BootAddr, valid=0).
  - the late rvalid causes no capture.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the Bourbon pipeline.
package beta_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    // addi x0, x0, 0: what the if-to-dec pipe holds when nothing has been fetched
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifs_state_t;

endpackage : beta_pkg

// File: rtl/beta_fetch_stage.sv
// Instruction fetch stage: takes fetch-enable pulses from the control unit,
// issues one imem request/grant/valid transaction per pulse and registers
// the returned instruction with its PC. A redirect reloads the PC and
// drops any response that belongs to the old path.
module beta_fetch_stage
    import beta_pkg::*;
#(
    parameter int unsigned             DataWidth = 32,
    parameter logic [DataWidth-1:0]    BootAddr  = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       ifs_fetch_en_i,
    output logic                       ifs_busy_o,

    output logic                       imem_req_o,
    output logic [DataWidth-1:0]       imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0]     imem_rdata_i,

    input  logic                       ifs_redirect_i,
    input  logic [DataWidth-1:0]       ifs_redirect_addr_i,

    output logic [INSTR_WIDTH-1:0]     ifs_instr_o,
    output logic [DataWidth-1:0]       ifs_pc_o,
    output logic                       ifs_valid_o
);

    ifs_state_t                 state_q, state_d;
    logic [DataWidth-1:0]       pc_q, pc_d;
    logic                       discard_q, discard_d;
    logic                       capture_c;
    logic [DataWidth-1:0]       redirect_pc_c;

    logic                       req_q;
    logic                       busy_q;
    logic [INSTR_WIDTH-1:0]     instr_q;
    logic [DataWidth-1:0]       pc_out_q;
    logic                       valid_q;

    // Redirect target forced onto a word boundary
    assign redirect_pc_c = ifs_redirect_addr_i & ~DataWidth'(3);

    // Next-state, PC and discard-flag logic; redirect overrides the increment
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        capture_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifs_fetch_en_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    state_d   = WAIT;
                    discard_d = ifs_redirect_i;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (discard_q || ifs_redirect_i) begin
                        // stale response: refetch at the new PC, stay busy
                        state_d   = REQ;
                        discard_d = 1'b0;
                    end else begin
                        capture_c = 1'b1;
                        state_d   = IDLE;
                        pc_d      = pc_q + DataWidth'(4);
                    end
                end else if (ifs_redirect_i) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase

        if (ifs_redirect_i) begin
            pc_d = redirect_pc_c;
        end
    end

    // Control state; req/busy are registered copies of the next-state decode
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pc_q      <= BootAddr;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            req_q     <= (state_d == REQ);
            busy_q    <= (state_d != IDLE);
        end
    end

    // if-to-dec output registers: load on capture, invalidate on redirect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q  <= NOP_INSTR;
            pc_out_q <= BootAddr;
            valid_q  <= 1'b0;
        end else if (capture_c) begin
            instr_q  <= imem_rdata_i;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
        end else if (ifs_redirect_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign ifs_busy_o  = busy_q;
    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign ifs_instr_o = instr_q;
    assign ifs_pc_o    = pc_out_q;
    assign ifs_valid_o = valid_q;

endmodule : beta_fetch_stage

// File: tb/tb_beta_fetch_stage.sv
// Bench for beta_fetch_stage: directed vector table, reset-abort sequence,
// then randomized stimulus against a transaction-level reference model.
module tb_beta_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ifs_fetch_en_i;
    logic        ifs_busy_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifs_redirect_i;
    logic [31:0] ifs_redirect_addr_i;
    logic [31:0] ifs_instr_o;
    logic [31:0] ifs_pc_o;
    logic        ifs_valid_o;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    beta_fetch_stage #(.DataWidth(32), .BootAddr(32'h0)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .ifs_fetch_en_i      (ifs_fetch_en_i),
        .ifs_busy_o          (ifs_busy_o),
        .imem_req_o          (imem_req_o),
        .imem_addr_o         (imem_addr_o),
        .imem_gnt_i          (imem_gnt_i),
        .imem_rvalid_i       (imem_rvalid_i),
        .imem_rdata_i        (imem_rdata_i),
        .ifs_redirect_i      (ifs_redirect_i),
        .ifs_redirect_addr_i (ifs_redirect_addr_i),
        .ifs_instr_o         (ifs_instr_o),
        .ifs_pc_o            (ifs_pc_o),
        .ifs_valid_o         (ifs_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        fen;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] raddr;
        logic        e_busy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fen, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic redir,
                       input logic [31:0] raddr, input logic e_busy,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_pc);
        vec_t v;
        v.fen = fen; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.redir = redir; v.raddr = raddr; v.e_busy = e_busy; v.e_req = e_req;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx,
                           input logic e_busy, input logic e_req,
                           input logic [31:0] e_addr, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pc);
        chk({tag, ".busy"},  idx, 32'(ifs_busy_o),  32'(e_busy));
        chk({tag, ".req"},   idx, 32'(imem_req_o),  32'(e_req));
        chk({tag, ".addr"},  idx, imem_addr_o,      e_addr);
        chk({tag, ".valid"}, idx, 32'(ifs_valid_o), 32'(e_valid));
        chk({tag, ".instr"}, idx, ifs_instr_o,      e_instr);
        chk({tag, ".pc"},    idx, ifs_pc_o,         e_pc);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        ifs_fetch_en_i      = 1'b0;
        imem_gnt_i          = 1'b0;
        imem_rvalid_i       = 1'b0;
        imem_rdata_i        = 32'h0;
        ifs_redirect_i      = 1'b0;
        ifs_redirect_addr_i = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Reference model: a fetch is "open" from the accepted enable until an
    // instruction is delivered; within it the request is either awaiting a
    // grant or awaiting data, and awaited data may be marked as stale.
    logic        m_open, m_granted, m_stale, m_valid;
    logic [31:0] m_pc, m_instr, m_pc_out;

    task automatic model_reset();
        m_open = 1'b0; m_granted = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
        m_pc = 32'h0; m_instr = NOP; m_pc_out = 32'h0;
    endtask

    task automatic model_step(input logic fen, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic redir,
                              input logic [31:0] raddr);
        logic [31:0] next_pc;
        next_pc = m_pc;
        if (!m_open) begin
            if (fen) m_open = 1'b1;
        end else if (!m_granted) begin
            if (gnt) begin
                m_granted = 1'b1;
                m_stale   = redir;
            end
        end else if (rv) begin
            m_granted = 1'b0;
            if (m_stale || redir) begin
                m_stale = 1'b0;
            end else begin
                m_instr  = rdata;
                m_pc_out = m_pc;
                m_valid  = 1'b1;
                m_open   = 1'b0;
                next_pc  = m_pc + 32'd4;
            end
        end else if (redir) begin
            m_stale = 1'b1;
        end
        if (redir) begin
            next_pc = {raddr[31:2], 2'b00};
            m_valid = 1'b0;
        end
        m_pc = next_pc;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;

        // Directed vectors: inputs for one cycle, outputs expected after the edge
        add(1,0,0,32'h0,0,32'h0,                1,1,32'h0,0,NOP,32'h0);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'h0,0,NOP,32'h0);
        add(0,0,1,32'h0050_0093,0,32'h0,        0,0,32'h4,1,32'h0050_0093,32'h0);
        add(1,0,0,32'h0,0,32'h0,                1,1,32'h4,1,32'h0050_0093,32'h0);
        for (int i = 0; i < 3; i++)
            add(0,0,0,32'h0,0,32'h0,            1,1,32'h4,1,32'h0050_0093,32'h0);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'h4,1,32'h0050_0093,32'h0);
        for (int i = 0; i < 2; i++)
            add(0,0,0,32'h0,0,32'h0,            1,0,32'h4,1,32'h0050_0093,32'h0);
        add(0,0,1,32'h1111_1111,0,32'h0,        0,0,32'h8,1,32'h1111_1111,32'h4);
        add(1,0,0,32'h0,0,32'h0,                1,1,32'h8,1,32'h1111_1111,32'h4);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'h8,1,32'h1111_1111,32'h4);
        add(0,0,0,32'h0,1,32'h103,              1,0,32'h100,0,32'h1111_1111,32'h4);
        add(0,0,1,32'hDEAD_BEEF,0,32'h0,        1,1,32'h100,0,32'h1111_1111,32'h4);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'h100,0,32'h1111_1111,32'h4);
        add(0,0,1,32'h2222_2222,0,32'h0,        0,0,32'h104,1,32'h2222_2222,32'h100);
        add(1,0,0,32'h0,0,32'h0,                1,1,32'h104,1,32'h2222_2222,32'h100);
        add(0,1,0,32'h0,1,32'h200,              1,0,32'h200,0,32'h2222_2222,32'h100);
        add(0,0,1,32'h3333_3333,0,32'h0,        1,1,32'h200,0,32'h2222_2222,32'h100);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'h200,0,32'h2222_2222,32'h100);
        add(0,0,1,32'h4444_4444,0,32'h0,        0,0,32'h204,1,32'h4444_4444,32'h200);
        add(0,0,0,32'h0,1,32'hFFFF_FFFF,        0,0,32'hFFFF_FFFC,0,32'h4444_4444,32'h200);
        add(1,0,0,32'h0,0,32'h0,                1,1,32'hFFFF_FFFC,0,32'h4444_4444,32'h200);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'hFFFF_FFFC,0,32'h4444_4444,32'h200);
        add(0,0,1,32'h5555_5555,0,32'h0,        0,0,32'h0,1,32'h5555_5555,32'hFFFF_FFFC);
        add(1,0,0,32'h0,1,32'h40,               1,1,32'h40,0,32'h5555_5555,32'hFFFF_FFFC);
        add(1,1,1,32'h6666_6666,0,32'h0,        1,0,32'h40,0,32'h5555_5555,32'hFFFF_FFFC);
        add(0,0,1,32'h7777_7777,0,32'h0,        0,0,32'h44,1,32'h7777_7777,32'h40);
        add(1,0,0,32'h0,0,32'h0,                1,1,32'h44,1,32'h7777_7777,32'h40);
        add(0,0,0,32'h0,1,32'h80,               1,1,32'h80,0,32'h7777_7777,32'h40);
        add(0,1,0,32'h0,0,32'h0,                1,0,32'h80,0,32'h7777_7777,32'h40);
        add(0,0,1,32'h8888_8888,0,32'h0,        0,0,32'h84,1,32'h8888_8888,32'h80);
        add(0,1,1,32'h9999_9999,0,32'h0,        0,0,32'h84,1,32'h8888_8888,32'h80);

        // Reset state
        tick();
        chk_all("reset", 0, 0, 0, 32'h0, 0, NOP, 32'h0);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            ifs_fetch_en_i      = vecs[i].fen;
            imem_gnt_i          = vecs[i].gnt;
            imem_rvalid_i       = vecs[i].rv;
            imem_rdata_i        = vecs[i].rdata;
            ifs_redirect_i      = vecs[i].redir;
            ifs_redirect_addr_i = vecs[i].raddr;
            tick();
            chk_all("vec", i, vecs[i].e_busy, vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
        end

        // Reset asserted while waiting for data; late rvalid must be ignored
        idle_inputs();
        ifs_fetch_en_i = 1'b1;
        tick();
        idle_inputs();
        imem_gnt_i = 1'b1;
        tick();
        idle_inputs();
        chk_all("pre_rst", 0, 1, 0, 32'h84, 1, 32'h8888_8888, 32'h80);
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 32'h0, 0, NOP, 32'h0);
        tick();
        rst_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        chk_all("late_rvalid", 0, 0, 0, 32'h0, 0, NOP, 32'h0);

        // Randomized stimulus against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            ifs_fetch_en_i      = ($urandom_range(0, 1) == 1);
            imem_gnt_i          = ($urandom_range(0, 9) < 4);
            imem_rvalid_i       = ($urandom_range(0, 9) < 4);
            imem_rdata_i        = $urandom;
            ifs_redirect_i      = ($urandom_range(0, 99) < 8);
            ifs_redirect_addr_i = $urandom;
            model_step(ifs_fetch_en_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
                       ifs_redirect_i, ifs_redirect_addr_i);
            tick();
            chk_all("rand", c, m_open, m_open && !m_granted, m_pc,
                    m_valid, m_instr, m_pc_out);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_beta_fetch_stage
